// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared constants, operator codes and state type for the RPN evaluator
package rpn_pkg;

    localparam int RPN_INT_W = 8;
    localparam int RPN_FRAC_W = 8;
    localparam int RPN_NW = RPN_INT_W + RPN_FRAC_W;

    // Bit that separates operators (1) from number literals (0) in a queue entry
    localparam int ENTRY_FLAG_BIT = RPN_NW;

    localparam logic [6:0] OP_ADD = 7'h2B;
    localparam logic [6:0] OP_SUB = 7'h2D;
    localparam logic [6:0] OP_MUL = 7'h2A;
    localparam logic [6:0] OP_X   = 7'h78;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rpn_evaluator_fixed_mul.sv
// rtl/rpn_evaluator_fixed_mul.sv - signed Q multiply with truncation; clamps when RPN_EVALUATOR_SATURATE_EN is defined
module fixed_mul
    import rpn_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH = RPN_INT_W,
    parameter int FRACTIONAL_PART_WIDTH = RPN_FRAC_W
) (
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] product
);

    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int FW = FRACTIONAL_PART_WIDTH;

    logic [2*NW-1:0] a_ext;
    logic [2*NW-1:0] b_ext;
    logic [2*NW-1:0] full;

    assign a_ext = {{NW{a[NW-1]}}, a};
    assign b_ext = {{NW{b[NW-1]}}, b};
    // Low 2*NW bits of the sign-extended product equal the exact signed product
    assign full = a_ext * b_ext;

`ifdef RPN_EVALUATOR_SATURATE_EN
    localparam logic [NW-1:0] MAX_VAL = {1'b0, {(NW-1){1'b1}}};
    localparam logic [NW-1:0] MIN_VAL = {1'b1, {(NW-1){1'b0}}};

    logic overflow;
    logic unused_low;

    // Kept field fits only if every bit above it matches its sign bit
    assign overflow = (full[2*NW-1:NW+FW-1] != {(NW-FW+1){full[2*NW-1]}});
    assign product = overflow ? (full[2*NW-1] ? MIN_VAL : MAX_VAL) : full[NW+FW-1:FW];
    assign unused_low = ^full[FW-1:0];
`else
    logic unused_bits;

    // Dropping low fraction bits of a two's complement value floors toward -inf
    assign product = full[NW+FW-1:FW];
    assign unused_bits = ^{full[2*NW-1:NW+FW], full[FW-1:0]};
`endif

endmodule

// File: rtl/rpn_evaluator.sv
// rtl/rpn_evaluator.sv - executes the parser's RPN queue on a value stack; overflow clamps when RPN_EVALUATOR_SATURATE_EN is defined
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH = RPN_INT_W,
    parameter int FRACTIONAL_PART_WIDTH = RPN_FRAC_W,
    parameter int OUTPUT_QUEUE_SIZE = 64,
    parameter int STACK_SIZE = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
    output logic                                                 ready,
    input  logic [$clog2(OUTPUT_QUEUE_SIZE)+1:0]                 queue_length,
    output logic [$clog2(OUTPUT_QUEUE_SIZE)+1:0]                 queue_read_index,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH:0]    queue_data_out,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]  x,
    output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]  result,
    output logic                                                 result_valid,
    output logic                                                 error
);

    localparam int NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int IW = $clog2(OUTPUT_QUEUE_SIZE) + 2;
    localparam int SAW = $clog2(STACK_SIZE);
    localparam int SPW = SAW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_SIZE);

    state_t          state;
    logic [NW-1:0]   x_lat;
    logic [IW-1:0]   qlen;
    logic [SPW-1:0]  sp;
    logic            err_flag;
    logic [NW-1:0]   stack_mem [STACK_SIZE];

    logic [SAW-1:0]  idx_top;
    logic [SAW-1:0]  idx_next;
    logic [NW-1:0]   top_val;
    logic [NW-1:0]   next_val;
    logic [IW-1:0]   next_index;

    logic [NW:0]     sum_ext;
    logic [NW:0]     diff_ext;
    logic [NW-1:0]   sum_val;
    logic [NW-1:0]   diff_val;
    logic [NW-1:0]   prod_val;

    logic            wr_en;
    logic [SAW-1:0]  wr_addr;
    logic [NW-1:0]   wr_data;
    logic [SPW-1:0]  sp_next;
    logic            exec_err;

    assign idx_top    = sp[SAW-1:0] - SAW'(1);
    assign idx_next   = sp[SAW-1:0] - SAW'(2);
    assign top_val    = stack_mem[idx_top];
    assign next_val   = stack_mem[idx_next];
    assign next_index = queue_read_index + IW'(1);

    // Operand a is next-to-top, b is top: a op b
    assign sum_ext  = {next_val[NW-1], next_val} + {top_val[NW-1], top_val};
    assign diff_ext = {next_val[NW-1], next_val} - {top_val[NW-1], top_val};

`ifdef RPN_EVALUATOR_SATURATE_EN
    localparam logic [NW-1:0] MAX_VAL = {1'b0, {(NW-1){1'b1}}};
    localparam logic [NW-1:0] MIN_VAL = {1'b1, {(NW-1){1'b0}}};

    // The two top bits disagree exactly when the true result leaves the NW-bit range
    assign sum_val  = (sum_ext[NW] != sum_ext[NW-1]) ? (sum_ext[NW] ? MIN_VAL : MAX_VAL) : sum_ext[NW-1:0];
    assign diff_val = (diff_ext[NW] != diff_ext[NW-1]) ? (diff_ext[NW] ? MIN_VAL : MAX_VAL) : diff_ext[NW-1:0];
`else
    logic unused_carry;

    assign sum_val      = sum_ext[NW-1:0];
    assign diff_val     = diff_ext[NW-1:0];
    assign unused_carry = sum_ext[NW] ^ diff_ext[NW];
`endif

    fixed_mul #(
        .INTEGER_PART_WIDTH    (INTEGER_PART_WIDTH),
        .FRACTIONAL_PART_WIDTH (FRACTIONAL_PART_WIDTH)
    ) u_fixed_mul (
        .a       (next_val),
        .b       (top_val),
        .product (prod_val)
    );

    // Decode the fetched entry into a stack write, new depth and error flag
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = sp[SAW-1:0];
        wr_data  = queue_data_out[NW-1:0];
        sp_next  = sp;
        exec_err = 1'b0;
        if (!queue_data_out[NW]) begin
            if (sp == SP_FULL) begin
                exec_err = 1'b1;
            end else begin
                wr_en   = 1'b1;
                sp_next = sp + SPW'(1);
            end
        end else begin
            case (queue_data_out[6:0])
                OP_X: begin
                    wr_data = x_lat;
                    if (sp == SP_FULL) begin
                        exec_err = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        sp_next = sp + SPW'(1);
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (sp < SPW'(2)) begin
                        exec_err = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = idx_next;
                        sp_next = sp - SPW'(1);
                        if (queue_data_out[6:0] == OP_ADD) begin
                            wr_data = sum_val;
                        end else if (queue_data_out[6:0] == OP_SUB) begin
                            wr_data = diff_val;
                        end else begin
                            wr_data = prod_val;
                        end
                    end
                end
                default: exec_err = 1'b1;
            endcase
        end
    end

    // Stack storage: written only in EXEC, contents are don't-care outside the live depth
    always_ff @(posedge clk) begin
        if (state == ST_EXEC && wr_en) begin
            stack_mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM with registered handshake, index and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            ready            <= 1'b1;
            result_valid     <= 1'b0;
            error            <= 1'b0;
            result           <= '0;
            queue_read_index <= '0;
            sp               <= '0;
            err_flag         <= 1'b0;
            x_lat            <= '0;
            qlen             <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (start) begin
                        ready            <= 1'b0;
                        x_lat            <= x;
                        qlen             <= queue_length;
                        sp               <= '0;
                        queue_read_index <= '0;
                        result           <= '0;
                        error            <= 1'b0;
                        if (queue_length == '0) begin
                            err_flag <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            err_flag <= 1'b0;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_err) begin
                        err_flag <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        sp               <= sp_next;
                        queue_read_index <= next_index;
                        state            <= (next_index < qlen) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_valid <= 1'b1;
                    state        <= ST_IDLE;
                    if (err_flag || sp != SPW'(1)) begin
                        error  <= 1'b1;
                        result <= '0;
                    end else begin
                        error  <= 1'b0;
                        result <= top_val;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb/tb_rpn_evaluator.sv - self-checking bench for rpn_evaluator
module tb_rpn_evaluator;
    import rpn_pkg::*;

    localparam int NW = 16;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [IW-1:0] queue_length;
    logic [IW-1:0] queue_read_index;
    logic [NW:0]   queue_data_out;
    logic [NW-1:0] x;
    logic [NW-1:0] result;
    logic          result_valid;
    logic          error;

    logic [NW:0]   mem [0:255];

    int vectors = 0;
    int miscompares = 0;

    rpn_evaluator dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .ready            (ready),
        .queue_length     (queue_length),
        .queue_read_index (queue_read_index),
        .queue_data_out   (queue_data_out),
        .x                (x),
        .result           (result),
        .result_valid     (result_valid),
        .error            (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) queue_data_out <= mem[queue_read_index];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NW:0] num(input int v);
        return {1'b0, 16'(v)};
    endfunction

    function automatic logic [NW:0] op(input logic [6:0] c);
        logic [NW:0] e;
        e = '0;
        e[ENTRY_FLAG_BIT] = 1'b1;
        e[6:0] = c;
        return e;
    endfunction

    function automatic int fix16(input int r);
        logic [15:0] t;
`ifdef RPN_EVALUATOR_SATURATE_EN
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
`else
        t = 16'(r);
        return int'($signed(t));
`endif
    endfunction

    // Reference: plain integer stack machine over mem[0..n-1]
    function automatic void model(input int n, input logic [15:0] xv,
                                  output int res, output int err, output int lat);
        int stk[$];
        int steps, a, b, r;
        logic [NW:0] e;
        err = 0;
        steps = 0;
        for (int i = 0; i < n; i++) begin
            steps = i + 1;
            e = mem[i];
            if (!e[NW] || e[6:0] == 7'h78) begin
                if (stk.size() == 16) begin err = 1; break; end
                stk.push_back(e[NW] ? int'($signed(xv)) : int'($signed(e[15:0])));
            end else if (e[6:0] == 7'h2B || e[6:0] == 7'h2D || e[6:0] == 7'h2A) begin
                if (stk.size() < 2) begin err = 1; break; end
                b = stk.pop_back();
                a = stk.pop_back();
                if (e[6:0] == 7'h2B) r = a + b;
                else if (e[6:0] == 7'h2D) r = a - b;
                else r = (a * b) >>> 8;
                stk.push_back(fix16(r));
            end else begin
                err = 1;
                break;
            end
        end
        if (n == 0 || stk.size() != 1) err = 1;
        res = err ? 0 : (stk[0] & 32'hFFFF);
        lat = 2 * steps + 2;
    endfunction

    task automatic run(input int n, input logic [15:0] xv,
                       output int got_res, output int got_err, output int got_lat);
        int w;
        queue_length = IW'(n);
        x = xv;
        w = 0;
        while (!ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready) check("ready_wait_timeout", 0, 1);
        start = 1'b1;
        got_lat = 0;
        while (1) begin
            @(posedge clk); #1;
            got_lat++;
            if (got_lat == 1) begin
                start = 1'b0;
                check("ready_fall", int'(ready), 0);
            end
            if (result_valid || got_lat > 200) break;
        end
        if (!result_valid) check("valid_timeout", 0, 1);
        got_res = int'(result);
        got_err = int'(error);
        @(posedge clk); #1;
        check("ready_rise", int'(ready), 1);
        check("valid_one_cycle", int'(result_valid), 0);
    endtask

    task automatic apply(input string tag, input int n, input logic [15:0] xv,
                         input bit has_exp, input int e_res, input int e_err, input int e_lat);
        int mr, me, ml, gr, ge, gl;
        model(n, xv, mr, me, ml);
        run(n, xv, gr, ge, gl);
        check({tag, "_result"}, gr, mr);
        check({tag, "_error"}, ge, me);
        check({tag, "_latency"}, gl, ml);
        if (has_exp) begin
            check({tag, "_result_tbl"}, gr, e_res);
            check({tag, "_error_tbl"}, ge, e_err);
            check({tag, "_latency_tbl"}, gl, e_lat);
        end
    endtask

    typedef struct packed {
        logic [3:0]       len;
        logic [4:0][16:0] ent;
        logic [15:0]      xv;
        logic [15:0]      res;
        logic             err;
        logic [7:0]       lat;
    } vec_t;

    function automatic logic [4:0][16:0] pk(input logic [16:0] e0, input logic [16:0] e1,
                                            input logic [16:0] e2, input logic [16:0] e3,
                                            input logic [16:0] e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    vec_t tbl [11];

    initial begin
        int gr, ge, gl, nvalid, n, depth, r;
        logic [15:0] xv;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        start = 1'b0;
        queue_length = '0;
        x = '0;

        tbl[0]  = '{4'd5, pk(num(16'h0100), num(16'h0200), op(7'h2A), num(16'h0300), op(7'h2B)), 16'h0000, 16'h0500, 1'b0, 8'd12};
        tbl[1]  = '{4'd3, pk(op(7'h78), op(7'h78), op(7'h2A), '0, '0), 16'h0180, 16'h0240, 1'b0, 8'd8};
        tbl[2]  = '{4'd3, pk(num(16'h0100), num(16'h0300), op(7'h2D), '0, '0), 16'h0000, 16'hFE00, 1'b0, 8'd8};
`ifdef RPN_EVALUATOR_SATURATE_EN
        tbl[3]  = '{4'd3, pk(num(16'h6400), num(16'h0200), op(7'h2A), '0, '0), 16'h0000, 16'h7FFF, 1'b0, 8'd8};
        tbl[9]  = '{4'd3, pk(num(16'h7000), num(16'h2000), op(7'h2B), '0, '0), 16'h0000, 16'h7FFF, 1'b0, 8'd8};
        tbl[10] = '{4'd3, pk(num(16'h8000), num(16'h0100), op(7'h2D), '0, '0), 16'h0000, 16'h8000, 1'b0, 8'd8};
`else
        tbl[3]  = '{4'd3, pk(num(16'h6400), num(16'h0200), op(7'h2A), '0, '0), 16'h0000, 16'hC800, 1'b0, 8'd8};
        tbl[9]  = '{4'd3, pk(num(16'h7000), num(16'h2000), op(7'h2B), '0, '0), 16'h0000, 16'h9000, 1'b0, 8'd8};
        tbl[10] = '{4'd3, pk(num(16'h8000), num(16'h0100), op(7'h2D), '0, '0), 16'h0000, 16'h7F00, 1'b0, 8'd8};
`endif
        tbl[4]  = '{4'd2, pk(num(16'h0100), op(7'h2B), '0, '0, '0), 16'h0000, 16'h0000, 1'b1, 8'd6};
        tbl[5]  = '{4'd2, pk(num(16'h0100), num(16'h0100), '0, '0, '0), 16'h0000, 16'h0000, 1'b1, 8'd6};
        tbl[6]  = '{4'd0, pk('0, '0, '0, '0, '0), 16'h0000, 16'h0000, 1'b1, 8'd2};
        tbl[7]  = '{4'd2, pk(num(16'h0100), op(7'h2F), '0, '0, '0), 16'h0000, 16'h0000, 1'b1, 8'd6};
        tbl[8]  = '{4'd3, pk(num(16'hFFFF), num(16'h0080), op(7'h2A), '0, '0), 16'h0000, 16'hFFFF, 1'b0, 8'd8};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(result_valid), 0);
        check("rst_error", int'(error), 0);
        check("rst_result", int'(result), 0);
        check("rst_index", int'(queue_read_index), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < 5; i++) mem[i] = tbl[k].ent[i];
            apply($sformatf("tbl%0d", k), int'(tbl[k].len), tbl[k].xv, 1'b1,
                  int'(tbl[k].res), int'(tbl[k].err), int'(tbl[k].lat));
        end

        // Full-depth stack: 16 pushes then 15 adds sums to 16.0
        for (int i = 0; i < 16; i++) mem[i] = num(16'h0100);
        for (int i = 16; i < 31; i++) mem[i] = op(7'h2B);
        apply("stack_full", 31, 16'h0, 1'b1, 16'h1000, 0, 64);

        // 17th push overflows the stack
        for (int i = 0; i < 17; i++) mem[i] = num(16'h0100);
        apply("stack_overflow", 17, 16'h0, 1'b1, 0, 1, 36);

        // Reset mid-run aborts without a result pulse
        for (int i = 0; i < 16; i++) mem[i] = num(16'h0100);
        for (int i = 16; i < 31; i++) mem[i] = op(7'h2B);
        apply("pre_abort", 31, 16'h0, 1'b1, 16'h1000, 0, 64);
        queue_length = 8'd31;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", int'(ready), 1);
        check("abort_valid", int'(result_valid), 0);
        check("abort_error", int'(error), 0);
        check("abort_result", int'(result), 0);
        check("abort_index", int'(queue_read_index), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (result_valid) nvalid++;
        end
        check("abort_no_valid", nvalid, 0);
        for (int i = 0; i < 5; i++) mem[i] = tbl[0].ent[i];
        apply("after_abort", 5, 16'h0, 1'b1, 16'h0500, 0, 12);

        // Start held high re-triggers on the first ready cycle
        mem[0] = num(16'h0100);
        mem[1] = num(16'h0200);
        mem[2] = op(7'h2B);
        queue_length = 8'd3;
        start = 1'b1;
        gl = 0;
        while (!result_valid && gl < 100) begin
            @(posedge clk); #1;
            gl++;
        end
        check("b2b_first_result", int'(result), 16'h0300);
        gl = 0;
        while (gl < 100) begin
            @(posedge clk); #1;
            gl++;
            if (result_valid) break;
        end
        start = 1'b0;
        check("b2b_gap", gl, 9);
        check("b2b_second_result", int'(result), 16'h0300);
        @(posedge clk); #1;

        // Randomized programs against the reference model
        for (int t = 0; t < 80; t++) begin
            n = $urandom_range(1, 24);
            depth = 0;
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    mem[i] = op(7'h2F);
                end else if (depth >= 2 && r < 50) begin
                    case ($urandom_range(0, 2))
                        0: mem[i] = op(7'h2B);
                        1: mem[i] = op(7'h2D);
                        default: mem[i] = op(7'h2A);
                    endcase
                    depth--;
                end else if (r < 60) begin
                    mem[i] = op(7'h78);
                    depth++;
                end else begin
                    mem[i] = ($urandom_range(0, 3) == 0) ? num(int'($urandom))
                                                          : num(int'($urandom_range(0, 2047)) - 1024);
                    depth++;
                end
            end
            xv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
            apply($sformatf("rand%0d", t), n, xv, 1'b0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rpn_evaluator.md
# rpn_evaluator

Evaluates the Reverse Polish Notation entry list that `parser` writes into the output queue, producing one signed Q8.8 result per run for a given variable value `x`. Sits directly downstream of `parser`: once the parser reports ready, the plotter core starts this block once per screen column. Entries are read back through the queue's read port and executed on an internal value stack.

## Interface
Parameters:
- `INTEGER_PART_WIDTH`, 8, integer bits of a value, sign included.
- `FRACTIONAL_PART_WIDTH`, 8, fractional bits of a value.
- `OUTPUT_QUEUE_SIZE`, 64, queue capacity; sets index width `IW = $clog2(OUTPUT_QUEUE_SIZE) + 2`, identical to the parser's index.
- `STACK_SIZE`, 16, evaluation stack depth in entries.

Ports (`NW = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH`):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin evaluation; sampled only while `ready`.
- `ready`  out  1  idle, accepts `start`.
- `queue_length`  in  IW  number of valid entries, indices 0 to `queue_length`-1.
- `queue_read_index`  out  IW  read address into the output queue.
- `queue_data_out`  in  NW+1  entry at the previous cycle's `queue_read_index`; 1-cycle read latency.
- `x`  in  NW  variable value, signed Q8.8; sampled at `start`.
- `result`  out  NW  signed Q8.8 result.
- `result_valid`  out  1  one-cycle pulse when `result` and `error` are final.
- `error`  out  1  run failed; `result` forced to 0.

## Operation
- Entry format: bit NW = 0 means number, bits [NW-1:0] are a signed Q8.8 literal to push. Bit NW = 1 means operator, bits [6:0] are an ASCII code.
- Operators: `+` pops b, pops a, pushes a+b. `-` pushes a-b. `*` pushes the Q8.8 product. `x` pushes the latched `x`.
- States:
  - IDLE: `ready`=1. On `start`: latch `x` and `queue_length`, clear stack pointer, index := 0, go to FETCH, or to DONE with error if `queue_length`=0.
  - FETCH: drive index, go to EXEC.
  - EXEC: decode `queue_data_out` and update the stack. Then index+1; go to FETCH if entries remain, else DONE.
  - DONE: `result` := stack top if depth is exactly 1, else error. Pulse `result_valid`, go to IDLE.
- Errors latch and jump straight to DONE:
  - stack underflow, meaning an operator with depth < 2;
  - push at depth `STACK_SIZE`;
  - unknown operator code;
  - final depth ≠ 1.
- Add and subtract: NW+1-bit intermediate, then overflow handling per Configuration.
- Multiply: 2·NW-bit signed product, keep bits [NW+FRACTIONAL_PART_WIDTH-1:FRACTIONAL_PART_WIDTH], which truncates toward −∞. Overflow handling per Configuration.
- `start` while busy is ignored. `result` and `error` hold until the next `start`.

## Timing
- Reset values: `ready`=1, `result_valid`=0, `error`=0, `result`=0, `queue_read_index`=0, state IDLE, stack pointer 0.
- `ready` falls the cycle after an accepted `start`.
- Latency for N entries: `start` edge to `result_valid` is 2N+2 cycles. `ready` rises the cycle after `result_valid`.
- `rst_n` low mid-run aborts immediately to reset values. No `result_valid` is produced.
- Back-to-back: `start` held high re-triggers on the first cycle `ready` is high.

## Configuration
- `RPN_EVALUATOR_SATURATE_EN` defined: add, subtract and multiply overflow clamp to 0x7FFF or 0x8000 (NW=16). `error` is not set.
- Undefined: results wrap modulo 2^NW. There is no saturation logic.

## Structure
- Package `rpn_pkg`:
  - entry flag bit position;
  - operator codes `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_X`;
  - state enum;
  - `NW` helper constants, shared with `parser`.
- Sub-module `fixed_mul`: combinational signed Q multiply, truncation and optional saturation under the same macro.
- Stack is a register array indexed by the stack pointer. Top and next-to-top are read combinationally.

## Test plan
- Entries 0x00100, 0x00200, `*`, 0x00300, `+` (1·2+3) -> `result`=0x0500, `error`=0, `result_valid` 12 cycles after `start`.
- `x`=0x0180, entries `x`, `x`, `*` -> `result`=0x0240.
- Entries 0x00100, 0x00300, `-` -> `result`=0xFE00.
- Entries 0x06400, 0x00200, `*` (100·2) -> 0x7FFF with the macro, 0xC800 without; `error`=0 in both cases.
- Entries 0x00100, `+` -> `error`=1, `result`=0. Entries 0x00100, 0x00100 -> `error`=1 (final depth 2). `queue_length`=0 -> `error`=1 after 2 cycles.
- `rst_n` pulsed low mid-run -> all outputs at reset values, `ready`=1. A following `start` evaluates correctly.
